mem_stage: RTL and testbench

//  Memory-access stage of the 5-stage LoongArch pipeline, between EXE and WB.

---
 rtl/mem_stage_pkg.sv | 41 ++++
 rtl/mem_stage_load_align.sv | 39 +++
 rtl/mem_stage.sv | 90 +++++++++
 tb/tb_mem_stage.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the EXE->MEM->WB boundary: bus widths, bus layouts and load opcodes.
// EXE and WB import this package so both ends of each bus agree on the field order.
package mem_stage_pkg;

    localparam int EXE_TO_MEM_WIDTH = 75;
    localparam int MEM_TO_WB_WIDTH  = 70;
    localparam int FWD_WIDTH        = 38;

    typedef enum logic [2:0] {
        OP_LDW  = 3'b000,
        OP_LDB  = 3'b001,
        OP_LDH  = 3'b010,
        OP_LDBU = 3'b011,
        OP_LDHU = 3'b100
    } mem_op_e;

    // Field order is the wire format; the first member lands in the MSBs.
    typedef struct packed {
        logic        mem_req;
        mem_op_e     mem_op;
        logic        res_from_mem;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } exe_to_mem_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic [31:0] pc;
    } mem_to_wb_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_fwd_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load aligner: picks the addressed byte/half from the raw word and extends it.
// Misaligned LD.H/LD.HU never reaches here, so addr[0] is ignored for halfwords.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  addr,
    input  logic [31:0] raw,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        w_byte = raw[7:0];
        case (addr)
            2'd1:    w_byte = raw[15:8];
            2'd2:    w_byte = raw[23:16];
            2'd3:    w_byte = raw[31:24];
            default: w_byte = raw[7:0];
        endcase
    end

    assign w_half = addr[1] ? raw[31:16] : raw[15:0];

    always_comb begin
        result = raw;
        case (op)
            OP_LDB:  result = {{24{w_byte[7]}}, w_byte};
            OP_LDH:  result = {{16{w_half[15]}}, w_half};
            OP_LDBU: result = {24'd0, w_byte};
            OP_LDHU: result = {16'd0, w_half};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage pipeline: holds one instruction, waits for its data-SRAM response,
// aligns load data and hands the result to WB, with a bypass/stall bundle back to ID.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                        clk,
    input  logic                        resetn,
    output logic                        mem_allowin,
    input  logic                        exe_to_mem_valid,
    input  logic [EXE_TO_MEM_WIDTH-1:0] exe_to_mem_wire,
    input  logic                        wb_allowin,
    output logic                        mem_to_wb_valid,
    output logic [MEM_TO_WB_WIDTH-1:0]  mem_to_wb_wire,
    input  logic                        data_sram_data_ok,
    input  logic [31:0]                 data_sram_rdata,
    output logic [FWD_WIDTH-1:0]        mem_fwd_zip,
    output logic                        mem_load_pending
);

    logic        r_mem_valid;
    logic        r_data_got;
    logic [31:0] r_rdata_buf;
    exe_to_mem_t r_payload;

    logic        w_ready_go;
    logic        w_load_in;
    logic        w_take_resp;
    logic [31:0] w_raw;
    logic [31:0] w_load_result;
    logic [31:0] w_rf_wdata;
    mem_to_wb_t  w_wb_bus;
    mem_fwd_t    w_fwd;

    assign w_ready_go   = ~r_payload.mem_req | r_data_got | data_sram_data_ok;
    assign mem_allowin  = ~r_mem_valid | (w_ready_go & wb_allowin);
    assign w_load_in    = exe_to_mem_valid & mem_allowin;
    // Only the first response for the resident instruction is kept; stray or late pulses are dropped.
    assign w_take_resp  = r_mem_valid & r_payload.mem_req & ~r_data_got & data_sram_data_ok;

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            r_mem_valid <= 1'b0;
            r_data_got  <= 1'b0;
            r_rdata_buf <= 32'd0;
            r_payload   <= '0;
        end else begin
            if (mem_allowin) begin
                r_mem_valid <= exe_to_mem_valid;
            end
            if (w_load_in) begin
                r_payload  <= exe_to_mem_t'(exe_to_mem_wire);
                r_data_got <= 1'b0;
            end else if (w_take_resp) begin
                r_data_got <= 1'b1;
            end
            if (w_take_resp) begin
                r_rdata_buf <= data_sram_rdata;
            end
        end
    end

    assign w_raw = r_data_got ? r_rdata_buf : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .op     (r_payload.mem_op),
        .addr   (r_payload.alu_result[1:0]),
        .raw    (w_raw),
        .result (w_load_result)
    );

    assign w_rf_wdata = r_payload.res_from_mem ? w_load_result : r_payload.alu_result;

    always_comb begin
        w_wb_bus.rf_we    = r_payload.rf_we;
        w_wb_bus.rf_waddr = r_payload.rf_waddr;
        w_wb_bus.rf_wdata = w_rf_wdata;
        w_wb_bus.pc       = r_payload.pc;

        w_fwd.rf_we       = r_payload.rf_we & r_mem_valid;
        w_fwd.rf_waddr    = r_payload.rf_waddr;
        w_fwd.rf_wdata    = w_rf_wdata;
    end

    assign mem_to_wb_valid  = r_mem_valid & w_ready_go;
    assign mem_to_wb_wire   = w_wb_bus;
    assign mem_fwd_zip      = w_fwd;
    assign mem_load_pending = r_mem_valid & r_payload.res_from_mem & ~w_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against a word-level load model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                        clk;
    logic                        resetn;
    logic                        mem_allowin;
    logic                        exe_to_mem_valid;
    logic [EXE_TO_MEM_WIDTH-1:0] exe_to_mem_wire;
    logic                        wb_allowin;
    logic                        mem_to_wb_valid;
    logic [MEM_TO_WB_WIDTH-1:0]  mem_to_wb_wire;
    logic                        data_sram_data_ok;
    logic [31:0]                 data_sram_rdata;
    logic [FWD_WIDTH-1:0]        mem_fwd_zip;
    logic                        mem_load_pending;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .mem_allowin       (mem_allowin),
        .exe_to_mem_valid  (exe_to_mem_valid),
        .exe_to_mem_wire   (exe_to_mem_wire),
        .wb_allowin        (wb_allowin),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .mem_to_wb_wire    (mem_to_wb_wire),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .mem_fwd_zip       (mem_fwd_zip),
        .mem_load_pending  (mem_load_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [74:0] make_exe(input logic mem_req, input logic [2:0] op,
                                             input logic res_mem, input logic we,
                                             input logic [4:0] waddr, input logic [31:0] alu,
                                             input logic [31:0] pc);
        return {mem_req, op, res_mem, we, waddr, alu, pc};
    endfunction

    // Reference load: shift the addressed lane down, mask it, then sign-extend arithmetically.
    function automatic logic [31:0] ref_load(input int op, input int addr, input logic [31:0] word);
        logic [31:0] lane;
        logic [31:0] b;
        logic [31:0] h;
        lane = word >> (8 * addr);
        b    = lane & 32'hFF;
        h    = lane & 32'hFFFF;
        case (op)
            1:       return (b >= 32'd128)   ? b - 32'd256   : b;
            2:       return (h >= 32'd32768) ? h - 32'd65536 : h;
            3:       return b;
            4:       return h;
            default: return word;
        endcase
    endfunction

    // Present one instruction for one edge; afterwards it is resident in MEM.
    task automatic issue(input logic [74:0] payload);
        exe_to_mem_valid = 1'b1;
        exe_to_mem_wire  = payload;
        #1;
        check("issue_allowin", mem_allowin, 1'b1);
        tick();
        exe_to_mem_valid = 1'b0;
        exe_to_mem_wire  = '0;
        #1;
    endtask

    function automatic logic [31:0] wdata_of(input logic [69:0] bus);
        return bus[63:32];
    endfunction

    initial begin
        logic [31:0] pc;
        logic [31:0] rd;
        logic [31:0] exp_w;

        resetn            = 1'b0;
        exe_to_mem_valid  = 1'b0;
        exe_to_mem_wire   = '0;
        wb_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        #3;
        check("rst_valid",   mem_to_wb_valid, 1'b0);
        check("rst_allowin", mem_allowin, 1'b1);
        check("rst_fwd",     mem_fwd_zip, 38'd0);
        check("rst_pending", mem_load_pending, 1'b0);
        check("rst_bus",     mem_to_wb_wire, 70'd0);
        tick();
        resetn = 1'b1;
        tick();

        // ALU op passes straight through in one cycle.
        pc = 32'h1C00_0010;
        issue(make_exe(1'b0, 3'd0, 1'b0, 1'b1, 5'd5, 32'h1234, pc));
        check("alu_valid", mem_to_wb_valid, 1'b1);
        check("alu_bus",   mem_to_wb_wire, {1'b1, 5'd5, 32'h1234, pc});
        check("alu_fwd",   mem_fwd_zip, {1'b1, 5'd5, 32'h1234});
        tick();
        check("alu_drain", mem_to_wb_valid, 1'b0);

        // LD.B / LD.BU from byte lane 3 with the response in the first MEM cycle.
        issue(make_exe(1'b1, 3'd1, 1'b1, 1'b1, 5'd6, 32'h1000_0003, pc + 4));
        check("ldb_pending_wait", mem_load_pending, 1'b1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_FF00;
        #1;
        check("ldb_valid",   mem_to_wb_valid, 1'b1);
        check("ldb_wdata",   wdata_of(mem_to_wb_wire), 32'hFFFF_FF80);
        check("ldb_pending", mem_load_pending, 1'b0);
        tick();
        data_sram_data_ok = 1'b0;
        issue(make_exe(1'b1, 3'd3, 1'b1, 1'b1, 5'd6, 32'h1000_0003, pc + 8));
        data_sram_data_ok = 1'b1;
        #1;
        check("ldbu_wdata", wdata_of(mem_to_wb_wire), 32'h0000_0080);
        tick();
        data_sram_data_ok = 1'b0;

        // LD.W with the response three cycles late.
        issue(make_exe(1'b1, 3'd0, 1'b1, 1'b1, 5'd7, 32'h2000_0000, pc + 12));
        for (int i = 0; i < 3; i++) begin
            check("ldw_late_pending", mem_load_pending, 1'b1);
            check("ldw_late_allowin", mem_allowin, 1'b0);
            check("ldw_late_valid",   mem_to_wb_valid, 1'b0);
            tick();
        end
        rd = $urandom;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        #1;
        check("ldw_late_done",  mem_to_wb_valid, 1'b1);
        check("ldw_late_wdata", wdata_of(mem_to_wb_wire), rd);
        tick();
        data_sram_data_ok = 1'b0;

        // Response arrives while WB is stalled; it must be held and not overwritten.
        issue(make_exe(1'b1, 3'd0, 1'b1, 1'b1, 5'd8, 32'h3000_0000, pc + 16));
        wb_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        check("buf_allowin", mem_allowin, 1'b0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h1234_5678;
        #1;
        check("buf_valid", mem_to_wb_valid, 1'b1);
        check("buf_hold",  wdata_of(mem_to_wb_wire), 32'hDEAD_BEEF);
        tick();
        wb_allowin        = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5555_5555;
        #1;
        check("buf_release", wdata_of(mem_to_wb_wire), 32'hDEAD_BEEF);
        check("buf_allow",   mem_allowin, 1'b1);
        tick();
        data_sram_data_ok = 1'b0;
        issue(make_exe(1'b1, 3'd0, 1'b1, 1'b1, 5'd8, 32'h3000_0004, pc + 20));
        check("buf_cleared", mem_load_pending, 1'b1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0BAD_F00D;
        #1;
        check("buf_next_wdata", wdata_of(mem_to_wb_wire), 32'h0BAD_F00D);
        tick();
        data_sram_data_ok = 1'b0;

        // Store waits one cycle for its response and never writes the register file.
        issue(make_exe(1'b1, 3'd0, 1'b0, 1'b0, 5'd0, 32'h4000_0000, pc + 24));
        check("st_wait_valid",   mem_to_wb_valid, 1'b0);
        check("st_wait_pending", mem_load_pending, 1'b0);
        check("st_wait_allowin", mem_allowin, 1'b0);
        tick();
        data_sram_data_ok = 1'b1;
        #1;
        check("st_valid",  mem_to_wb_valid, 1'b1);
        check("st_we",     mem_to_wb_wire[69], 1'b0);
        check("st_fwd_we", mem_fwd_zip[37], 1'b0);
        tick();
        data_sram_data_ok = 1'b0;

        // Reset while a load is pending; the late response must be ignored.
        issue(make_exe(1'b1, 3'd0, 1'b1, 1'b1, 5'd9, 32'h5000_0000, pc + 28));
        check("rstmid_pending_before", mem_load_pending, 1'b1);
        resetn = 1'b0;
        #1;
        check("rstmid_valid",   mem_to_wb_valid, 1'b0);
        check("rstmid_pending", mem_load_pending, 1'b0);
        check("rstmid_fwd",     mem_fwd_zip, 38'd0);
        tick();
        resetn            = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBAD0_BAD0;
        #1;
        check("late_ok_valid", mem_to_wb_valid, 1'b0);
        tick();
        data_sram_data_ok = 1'b0;
        issue(make_exe(1'b0, 3'd0, 1'b0, 1'b1, 5'd7, 32'h77, pc + 32));
        check("post_rst_bus", mem_to_wb_wire, {1'b1, 5'd7, 32'h77, pc + 32});
        tick();
        issue(make_exe(1'b1, 3'd0, 1'b1, 1'b1, 5'd10, 32'h6000_0000, pc + 36));
        check("post_rst_load_waits", mem_load_pending, 1'b1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_0001;
        #1;
        check("post_rst_load", wdata_of(mem_to_wb_wire), 32'hCAFE_0001);
        tick();
        data_sram_data_ok = 1'b0;

        // Randomized loads: random op, lane, response delay and WB stall.
        for (int n = 0; n < 60; n++) begin
            int op;
            int addr;
            int delay;
            int stall;
            logic [4:0] wa;
            op    = $urandom_range(0, 4);
            addr  = $urandom_range(0, 3);
            if (op == 0) addr = 0;
            if (op == 2 || op == 4) addr = addr & 2;
            delay = $urandom_range(0, 3);
            stall = $urandom_range(0, 2);
            wa    = 5'($urandom_range(1, 31));
            rd    = $urandom;
            exp_w = ref_load(op, addr, rd);
            pc    = $urandom;
            issue(make_exe(1'b1, 3'(op), 1'b1, 1'b1, wa,
                           {$urandom_range(0, 32'h3FFF_FFFF), 2'(addr)}, pc));
            for (int d = 0; d < delay; d++) begin
                data_sram_rdata = $urandom;
                #1;
                check("rnd_wait_pending", mem_load_pending, 1'b1);
                check("rnd_wait_valid",   mem_to_wb_valid, 1'b0);
                tick();
            end
            wb_allowin        = (stall == 0);
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = rd;
            #1;
            check("rnd_valid", mem_to_wb_valid, 1'b1);
            check("rnd_bus",   mem_to_wb_wire, {1'b1, wa, exp_w, pc});
            check("rnd_fwd",   mem_fwd_zip, {1'b1, wa, exp_w});
            tick();
            for (int s = 1; s <= stall; s++) begin
                data_sram_data_ok = 1'b0;
                data_sram_rdata   = $urandom;
                wb_allowin        = (s == stall);
                #1;
                check("rnd_stall_wdata", wdata_of(mem_to_wb_wire), exp_w);
                tick();
            end
            data_sram_data_ok = 1'b0;
            wb_allowin        = 1'b1;
            #1;
            check("rnd_drain", mem_to_wb_valid, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
